// File: rtl/systolic_mm_nxn.sv
// Output-stationary NxN systolic multiplier: C = A x B for an NxK by KxN operand pair.
// Operands are skewed on entry and flow right/down with valid tokens; the FSM frames one job.

module systolic_mm_nxn_pe #(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [W-1:0]     i_a,
    input  logic             i_at,
    input  logic [W-1:0]     i_b,
    input  logic             i_bt,
    output logic [W-1:0]     o_a,
    output logic             o_at,
    output logic [W-1:0]     o_b,
    output logic             o_bt,
    output logic [ACC_W-1:0] o_acc
);
    logic [W-1:0]     r_a, r_b;
    logic             r_at, r_bt;
    logic [ACC_W-1:0] r_acc;
    logic [2*W-1:0]   w_prod;

    assign w_prod = i_a * i_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_at  <= 1'b0;
            r_bt  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_at <= i_at;
            r_bt <= i_bt;
            if (i_clr)
                r_acc <= '0;
            else if (i_at && i_bt)
                r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_a   = r_a;
    assign o_at  = r_at;
    assign o_b   = r_b;
    assign o_bt  = r_bt;
    assign o_acc = r_acc;
endmodule

module systolic_mm_nxn #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [N*W-1:0]       a_col,
    input  logic [N*W-1:0]       b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*ACC_W-1:0] c_flat,
    output logic                 busy
);
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready, r_out_valid, r_busy;
    logic            w_accept, w_clr;

    logic [N-1:0][N:0][W-1:0] w_a;
    logic [N-1:0][N:0]        w_at;
    logic [N:0][N-1:0][W-1:0] w_b;
    logic [N:0][N-1:0]        w_bt;

    assign w_accept = in_valid & r_in_ready;
    assign w_clr    = (r_state == S_IDLE) & start;

    // Drain length covers the token wavefront reaching PE(N-1,N-1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state    <= S_LOAD;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b1;
                end
                S_LOAD: if (w_accept && in_last) begin
                    r_state    <= S_DRAIN;
                    r_in_ready <= 1'b0;
                    r_cnt      <= '0;
                end
                S_DRAIN: begin
                    if (r_cnt == CW'(2 * N - 2)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    // Stage 0 is the input register; row/column g gets g extra stages of skew.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [gi:0][W-1:0] r_ash, r_bsh;
        logic [gi:0]        r_atk, r_btk;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ash <= '0;
                r_bsh <= '0;
                r_atk <= '0;
                r_btk <= '0;
            end else begin
                r_ash[0] <= a_col[gi*W +: W];
                r_bsh[0] <= b_row[gi*W +: W];
                r_atk[0] <= w_accept;
                r_btk[0] <= w_accept;
                for (int d = 1; d <= gi; d++) begin
                    r_ash[d] <= r_ash[d-1];
                    r_bsh[d] <= r_bsh[d-1];
                    r_atk[d] <= r_atk[d-1];
                    r_btk[d] <= r_btk[d-1];
                end
            end
        end

        assign w_a[gi][0]  = r_ash[gi];
        assign w_at[gi][0] = r_atk[gi];
        assign w_b[0][gi]  = r_bsh[gi];
        assign w_bt[0][gi] = r_btk[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_mm_nxn_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .i_clr (w_clr),
                .i_a   (w_a[gi][gj]),
                .i_at  (w_at[gi][gj]),
                .i_b   (w_b[gi][gj]),
                .i_bt  (w_bt[gi][gj]),
                .o_a   (w_a[gi][gj+1]),
                .o_at  (w_at[gi][gj+1]),
                .o_b   (w_b[gi+1][gj]),
                .o_bt  (w_bt[gi+1][gj]),
                .o_acc (c_flat[(gi*N+gj)*ACC_W +: ACC_W])
            );
        end
    end

    // Operands leaving the right and bottom edges have no consumer.
    logic w_unused;
    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < N; i++)
            w_unused = w_unused ^ (^{w_a[i][N], w_at[i][N], w_b[N][i], w_bt[N][i]});
    end
endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Directed bench: N=4/ACC_W=20 and N=2/ACC_W=16 instances, hand-computed results.
module tb_systolic_mm_nxn;
    localparam int N4 = 4, N2 = 2, W = 8, AC4 = 20, AC2 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic s4 = 0, iv4 = 0, il4 = 0, or4 = 0, ir4, ov4, bz4;
    logic [N4*W-1:0] a4 = '0, b4 = '0;
    logic [N4*N4*AC4-1:0] c4;
    logic s2 = 0, iv2 = 0, il2 = 0, or2 = 0, ir2, ov2, bz2;
    logic [N2*W-1:0] a2 = '0, b2 = '0;
    logic [N2*N2*AC2-1:0] c2;

    systolic_mm_nxn #(.N(N4), .W(W), .ACC_W(AC4)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4), .in_valid(iv4), .in_ready(ir4), .in_last(il4),
        .a_col(a4), .b_row(b4), .out_valid(ov4), .out_ready(or4), .c_flat(c4), .busy(bz4));

    systolic_mm_nxn #(.N(N2), .W(W), .ACC_W(AC2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2), .in_valid(iv2), .in_ready(ir2), .in_last(il2),
        .a_col(a2), .b_row(b2), .out_valid(ov2), .out_ready(or2), .c_flat(c2), .busy(bz2));

    int n_chk = 0, n_pass = 0;
    logic [N4*W-1:0] A4 [0:7];
    logic [N4*W-1:0] B4 [0:7];
    logic [N2*W-1:0] A2 [0:3];
    logic [N2*W-1:0] B2 [0:3];
    int E4 [16];
    int E2 [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_c4(input string tg);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_c%0d", tg, i), 64'(c4[i*AC4 +: AC4]), 64'(E4[i]));
    endtask

    task automatic chk_c2(input string tg);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_c%0d", tg, i), 64'(c2[i*AC2 +: AC2]), 64'(E2[i]));
    endtask

    // Start a job, feed nb beats (optionally with bubbles carrying a stray in_last), measure latency.
    task automatic run4(input string tg, input int nb, input bit bub, input int exp_lat);
        int lat;
        bit ok;
        ok = 1;
        @(negedge clk) s4 = 1;
        @(negedge clk) s4 = 0;
        for (int k = 0; k < nb; k++) begin
            if (bub && k > 0) begin
                iv4 = 0; il4 = 1; a4 = '1; b4 = '1;
                @(negedge clk);
            end
            if (!ir4 || !bz4) ok = 0;
            iv4 = 1; a4 = A4[k]; b4 = B4[k]; il4 = (k == nb - 1);
            @(negedge clk);
        end
        iv4 = 0; il4 = 0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            if (!bz4 || ir4) ok = 0;
            @(negedge clk);
            lat++;
        end
        chk({tg, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tg, "_busy_rdy"}, 64'(ok), 64'd1);
    endtask

    task automatic run2(input string tg, input int nb, input int exp_lat);
        int lat;
        bit ok;
        ok = 1;
        @(negedge clk) s2 = 1;
        @(negedge clk) s2 = 0;
        for (int k = 0; k < nb; k++) begin
            if (!ir2 || !bz2) ok = 0;
            iv2 = 1; a2 = A2[k]; b2 = B2[k]; il2 = (k == nb - 1);
            @(negedge clk);
        end
        iv2 = 0; il2 = 0;
        lat = 0;
        while (!ov2 && lat < 40) begin
            if (!bz2 || ir2) ok = 0;
            @(negedge clk);
            lat++;
        end
        chk({tg, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tg, "_busy_rdy"}, 64'(ok), 64'd1);
    endtask

    task automatic pop4(input string tg);
        or4 = 1;
        @(negedge clk);
        or4 = 0;
        chk({tg, "_ov_drop"}, 64'(ov4), 64'd0);
        chk({tg, "_idle"}, 64'(bz4), 64'd0);
    endtask

    task automatic pop2(input string tg);
        or2 = 1;
        @(negedge clk);
        or2 = 0;
        chk({tg, "_ov_drop"}, 64'(ov2), 64'd0);
        chk({tg, "_idle"}, 64'(bz2), 64'd0);
    endtask

    initial begin
        logic [N4*N4*AC4-1:0] snap;
        bit ok;

        repeat (3) @(negedge clk);
        chk("rst_ir4", 64'(ir4), 0); chk("rst_ov4", 64'(ov4), 0); chk("rst_bz4", 64'(bz4), 0);
        chk("rst_c4", 64'(c4 == '0), 1);
        chk("rst_ir2", 64'(ir2), 0); chk("rst_ov2", 64'(ov2), 0); chk("rst_bz2", 64'(bz2), 0);
        chk("rst_c2", 64'(c2 == '0), 1);
        rst = 0;

        // N=2: A=[[1,2],[3,4]] times identity
        A2[0] = {8'd3, 8'd1}; A2[1] = {8'd4, 8'd2};
        B2[0] = {8'd0, 8'd1}; B2[1] = {8'd1, 8'd0};
        E2 = '{1, 2, 3, 4};
        run2("ident", 2, 3);
        chk_c2("ident");
        pop2("ident");

        // N=2, ACC_W=16 wrap: 2*255*255 mod 65536
        A2[0] = 16'hFFFF; A2[1] = 16'hFFFF; B2[0] = 16'hFFFF; B2[1] = 16'hFFFF;
        E2 = '{64514, 64514, 64514, 64514};
        run2("wrap", 2, 3);
        chk_c2("wrap");
        pop2("wrap");

        // N=4, K=4 with bubbles: A[i][k]=i+k+1, B[k][j]=k*j+1
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                A4[k][i*W +: W] = 8'(i + k + 1);
                B4[k][i*W +: W] = 8'(k * i + 1);
            end
        E4 = '{10, 30, 50, 70, 14, 40, 66, 92, 18, 50, 82, 114, 22, 60, 98, 136};
        run4("bub", 4, 1, 7);
        chk_c4("bub");
        pop4("bub");

        // K=1 then back-pressure with ignored start pulses
        A4[0] = {4{8'd2}}; B4[0] = {4{8'd3}};
        for (int i = 0; i < 16; i++) E4[i] = 6;
        run4("k1", 1, 0, 7);
        chk_c4("k1");
        snap = c4;
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            s4 = c[0];
            @(negedge clk);
            if (ov4 !== 1'b1 || c4 !== snap || bz4 !== 1'b1) ok = 0;
        end
        s4 = 0;
        chk("bp_hold", 64'(ok), 64'd1);
        pop4("bp");

        // Second job must start from cleared accumulators: C = 5 + (i+1)(j+1)
        A4[0] = {4{8'd1}}; B4[0] = {4{8'd5}};
        A4[1] = {8'd4, 8'd3, 8'd2, 8'd1}; B4[1] = {8'd4, 8'd3, 8'd2, 8'd1};
        E4 = '{6, 7, 8, 9, 7, 9, 11, 13, 8, 11, 14, 17, 9, 13, 17, 21};
        run4("job2", 2, 0, 7);
        chk_c4("job2");
        pop4("job2");

        // Reset after two accepted beats of LOAD
        @(negedge clk) s4 = 1;
        @(negedge clk) s4 = 0;
        iv4 = 1; il4 = 0; a4 = {4{8'd50}}; b4 = {4{8'd60}};
        @(negedge clk);
        @(negedge clk);
        iv4 = 0; rst = 1;
        @(negedge clk);
        chk("mid_rst_ir", 64'(ir4), 0); chk("mid_rst_bz", 64'(bz4), 0);
        chk("mid_rst_ov", 64'(ov4), 0); chk("mid_rst_c", 64'(c4 == '0), 1);
        rst = 0;
        A4[0] = {4{8'd7}}; B4[0] = {4{8'd9}};
        for (int i = 0; i < 16; i++) E4[i] = 63;
        run4("post_rst", 1, 0, 7);
        chk_c4("post_rst");
        pop4("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
